// File: rtl/seg_scan_pkg.sv
// Shared constants, types and helpers for the seven-segment scan encoder family.
package seg_scan_pkg;

  localparam int SEG_POS_W      = 3;
  localparam int SEG_NIB_W      = 4;
  localparam int SEG_NUM_DIGITS = 8;
  localparam int SEG_POS_LSB    = 0;
  localparam int SEG_NIB_LSB    = 3;
  localparam int SEG_WORD_W     = 32;
  localparam int SEG_VALUE_W    = SEG_NIB_W * SEG_NUM_DIGITS;
  localparam int SEG_RSVD_W     = SEG_WORD_W - SEG_NIB_W - SEG_POS_W;

  typedef enum logic {
    IDLE,
    SCAN
  } seg_scan_state_t;

  typedef struct packed {
    logic [SEG_RSVD_W-1:0] rsvd;
    logic [SEG_NIB_W-1:0]  nib;
    logic [SEG_POS_W-1:0]  pos;
  } seg_word_t;

  // Returns {wrap, next_pos}: the next enabled index above pos, or the lowest
  // enabled index with wrap set when nothing above pos is enabled.
  function automatic logic [SEG_POS_W:0] next_enabled(
    input logic [SEG_POS_W-1:0]      pos,
    input logic [SEG_NUM_DIGITS-1:0] en
  );
    logic [SEG_POS_W-1:0] lowest;
    logic [SEG_POS_W-1:0] above;
    logic                 found;
    lowest = '0;
    above  = '0;
    found  = 1'b0;
    for (int i = SEG_NUM_DIGITS - 1; i >= 0; i--) begin
      if (en[i]) begin
        lowest = SEG_POS_W'(i);
        if (i > int'(pos)) begin
          above = SEG_POS_W'(i);
          found = 1'b1;
        end
      end
    end
    return found ? {1'b0, above} : {1'b1, lowest};
  endfunction

  function automatic seg_word_t seg_word(
    input logic [SEG_VALUE_W-1:0] value,
    input logic [SEG_POS_W-1:0]   pos
  );
    seg_word_t w;
    w     = '0;
    w.nib = value[{pos, 2'b00} +: SEG_NIB_W];
    w.pos = pos;
    return w;
  endfunction

endpackage

// File: rtl/seg_prescaler.sv
// Free-running divider producing a one-cycle tick every CLK_DIV cycles while Run is high.
module seg_prescaler #(
  parameter int CLK_DIV = 100000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  output logic Tick
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // Dropping Run discards any partial count so the next run starts a full slot.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else if (!Run || cnt_q == TERM) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign Tick = Run && (cnt_q == TERM);

endmodule

// File: rtl/seg_scan_encoder.sv
// Time-multiplexes a 32-bit hex value into {nibble, position} words for the segment controller.
// Define SEG_SCAN_SHADOW_EN to defer loads into a shadow register committed at frame wrap.
module seg_scan_encoder
  import seg_scan_pkg::*;
#(
  parameter int CLK_DIV = 100000
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [SEG_VALUE_W-1:0]    Value_In,
  input  logic                      Value_Valid,
  output logic                      Value_Ready,
  input  logic [SEG_NUM_DIGITS-1:0] Digit_En,
  output logic [SEG_WORD_W-1:0]     Seg_Display,
  output logic                      Frame_Done
);

  seg_scan_state_t      state_q;
  seg_scan_state_t      state_d;
  logic [SEG_POS_W-1:0] pos_q;
  logic [SEG_POS_W-1:0] pos_d;
  logic [SEG_VALUE_W-1:0] value_q;
  logic [SEG_VALUE_W-1:0] disp_value;
  logic                 any_en;
  logic                 run;
  logic                 tick;
  logic                 issue;
  logic                 wrap;
  seg_word_t            word_d;

  assign any_en = |Digit_En;
  assign run    = (state_q == SCAN) && any_en;

  seg_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .Clk   (Clk),
    .Reset (Reset),
    .Run   (run),
    .Tick  (tick)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_en)  state_d = SCAN;
      SCAN:    if (!any_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Leaving IDLE searches upward from the top digit, so it always lands on the
  // lowest enabled position and reports a wrap (new frame).
  always_comb begin
    issue = 1'b0;
    wrap  = 1'b0;
    pos_d = pos_q;
    unique case (state_q)
      IDLE: begin
        if (any_en) begin
          issue         = 1'b1;
          {wrap, pos_d} = next_enabled(SEG_POS_W'(SEG_NUM_DIGITS - 1), Digit_En);
        end
      end
      SCAN: begin
        if (tick) begin
          issue         = 1'b1;
          {wrap, pos_d} = next_enabled(pos_q, Digit_En);
        end
      end
      default: ;
    endcase
  end

  assign word_d = seg_word(disp_value, pos_d);

  // Output stage: word and frame marker registered together on each issue.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pos_q       <= '0;
      Seg_Display <= '0;
      Frame_Done  <= 1'b0;
    end else begin
      Frame_Done <= issue & wrap;
      if (issue) begin
        pos_q       <= pos_d;
        Seg_Display <= word_d;
      end
    end
  end

`ifdef SEG_SCAN_SHADOW_EN
  logic [SEG_VALUE_W-1:0] shadow_q;
  logic                   pending_q;
  logic                   commit;

  // A committing word already shows the shadowed value.
  assign commit      = issue & wrap & pending_q;
  assign disp_value  = commit ? shadow_q : value_q;
  assign Value_Ready = ~pending_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      value_q   <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else if (Value_Valid && !pending_q) begin
      shadow_q  <= Value_In;
      pending_q <= 1'b1;
    end else if (commit) begin
      value_q   <= shadow_q;
      pending_q <= 1'b0;
    end
  end
`else
  assign disp_value  = value_q;
  assign Value_Ready = 1'b1;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      value_q <= '0;
    end else if (Value_Valid) begin
      value_q <= Value_In;
    end
  end
`endif

endmodule

// File: tb/tb_seg_scan_encoder.sv
// Scoreboard bench for seg_scan_encoder with CLK_DIV = 4 and a cycle-level reference model.
module tb_seg_scan_encoder;

  localparam int CLK_DIV = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] Value_In = '0;
  logic        Value_Valid = 1'b0;
  logic        Value_Ready;
  logic [7:0]  Digit_En = '0;
  logic [31:0] Seg_Display;
  logic        Frame_Done;

  always #5 Clk = ~Clk;

  seg_scan_encoder #(
    .CLK_DIV (CLK_DIV)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Value_In    (Value_In),
    .Value_Valid (Value_Valid),
    .Value_Ready (Value_Ready),
    .Digit_En    (Digit_En),
    .Seg_Display (Seg_Display),
    .Frame_Done  (Frame_Done)
  );

  typedef struct {
    logic [31:0] word;
    logic        fd;
    logic        rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err = 0;

  // Reference model state
  bit          m_scan;
  int          m_pos;
  int          m_cnt;
  logic [31:0] m_value;
  logic [31:0] m_shadow;
  bit          m_pending;
  logic [31:0] m_word;
  bit          m_fd;
  bit          m_rdy = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_en(input logic [7:0] en);
    for (int p = 0; p < 8; p++) if (en[p]) return p;
    return 0;
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] v, input int p);
    return (((v >> (4 * p)) & 32'hF) << 3) | 32'(p);
  endfunction

  // Applies the effect of the coming clock edge given the current inputs.
  task automatic model_edge();
    bit issue;
    bit wrap;
    int np;
    bit rdy_before;
    issue      = 1'b0;
    wrap       = 1'b0;
    np         = m_pos;
    rdy_before = !m_pending;
    if (!Reset) begin
      m_scan = 0; m_pos = 0; m_cnt = 0; m_value = '0; m_shadow = '0;
      m_pending = 0; m_word = '0; m_fd = 0; m_rdy = 1'b1;
      return;
    end
    m_fd = 1'b0;
    if (!m_scan) begin
      if (Digit_En != 0) begin
        issue = 1; wrap = 1; np = lowest_en(Digit_En); m_scan = 1; m_cnt = 0;
      end
    end else if (Digit_En == 0) begin
      m_scan = 0; m_cnt = 0;
    end else if (m_cnt == CLK_DIV - 1) begin
      m_cnt = 0; issue = 1; wrap = 1; np = lowest_en(Digit_En);
      for (int p = m_pos + 1; p < 8; p++) begin
        if (Digit_En[p]) begin
          np = p; wrap = 0; break;
        end
      end
    end else begin
      m_cnt++;
    end
`ifdef SEG_SCAN_SHADOW_EN
    if (issue && wrap && m_pending) begin
      m_value = m_shadow; m_pending = 0;
    end
`endif
    if (issue) begin
      m_pos = np; m_word = word_of(m_value, np); m_fd = wrap;
    end
`ifdef SEG_SCAN_SHADOW_EN
    if (Value_Valid && rdy_before) begin
      m_shadow = Value_In; m_pending = 1;
    end
    m_rdy = !m_pending;
`else
    if (Value_Valid) m_value = Value_In;
    m_rdy = 1'b1;
`endif
  endtask

  task automatic step();
    exp_t e;
    model_edge();
    @(posedge Clk);
    e.word = m_word; e.fd = m_fd; e.rdy = m_rdy;
    exp_q.push_back(e);
    #1;
  endtask

  // Asserts reset away from the edge with a load request present.
  task automatic assert_reset();
    @(negedge Clk);
    #1;
    Reset = 1'b0;
    Value_Valid = 1'b1;
    Value_In = 32'hDEAD_BEEF;
    #1;
    check("reset_word", Seg_Display, 32'h0);
    check("reset_fd", {31'b0, Frame_Done}, 32'h0);
    check("reset_ready", {31'b0, Value_Ready}, 32'h1);
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("word", Seg_Display, e.word);
      check("frame_done", {31'b0, Frame_Done}, {31'b0, e.fd});
      check("ready", {31'b0, Value_Ready}, {31'b0, e.rdy});
    end
  end

  initial begin
    Reset = 1'b0;
    step(); step();
    Reset = 1'b1;

    // All digits, value 89ABCDEF loaded while idle
    Value_In = 32'h89AB_CDEF; Value_Valid = 1'b1; step();
    Value_Valid = 1'b0; Digit_En = 8'hFF; step();
    check("s1_w0", Seg_Display, 32'h78);
    check("s1_fd0", {31'b0, Frame_Done}, 32'h1);
    repeat (4) step();
    check("s1_w1", Seg_Display, 32'h71);
    check("s1_fd1", {31'b0, Frame_Done}, 32'h0);
    repeat (24) step();
    check("s1_w7", Seg_Display, 32'h47);
    repeat (4) step();
    check("s1_wrap", Seg_Display, 32'h78);
    check("s1_wrap_fd", {31'b0, Frame_Done}, 32'h1);

    // Sparse enable 1000_0101
    Digit_En = 8'h00; step();
    Value_In = 32'h1234_5678; Value_Valid = 1'b1; step();
    Value_Valid = 1'b0; Digit_En = 8'b1000_0101; step();
    check("s2_p0", Seg_Display, 32'h40);
    repeat (4) step();
    check("s2_p2", Seg_Display, 32'h32);
    repeat (4) step();
    check("s2_p7", Seg_Display, 32'h0F);
    repeat (4) step();
    check("s2_wrap", Seg_Display, 32'h40);
    check("s2_wrap_fd", {31'b0, Frame_Done}, 32'h1);

    // Single digit: every tick is a wrap
    Digit_En = 8'h00; step();
    Value_In = 32'h0003_0000; Value_Valid = 1'b1; step();
    Value_Valid = 1'b0; Digit_En = 8'h10; step();
    check("s3_w", Seg_Display, 32'h1C);
    check("s3_fd", {31'b0, Frame_Done}, 32'h1);
    repeat (4) step();
    check("s3_fd_again", {31'b0, Frame_Done}, 32'h1);
    repeat (2) step();

    // Drop enables mid-slot, then re-enable
    Digit_En = 8'h00; repeat (5) step();
    check("s4_freeze", Seg_Display, 32'h1C);
    Digit_En = 8'h10; step();
    check("s4_restart_fd", {31'b0, Frame_Done}, 32'h1);

`ifdef SEG_SCAN_SHADOW_EN
    // Shadow load at position 3, second request ignored while pending
    Digit_En = 8'h00; step();
    Digit_En = 8'hFF; step();
    repeat (12) step();
    Value_In = 32'h0000_000A; Value_Valid = 1'b1; step();
    check("sh_ready_low", {31'b0, Value_Ready}, 32'h0);
    Value_In = 32'h0000_0005; step();
    Value_Valid = 1'b0; repeat (18) step();
    check("sh_commit_word", Seg_Display, 32'h50);
    step();
    check("sh_ready_back", {31'b0, Value_Ready}, 32'h1);
`endif

    // Reset with a load in flight; the loaded value must never appear
    Digit_En = 8'hFF;
    Value_In = 32'hDEAD_BEEF; Value_Valid = 1'b1; step();
    Value_Valid = 1'b0; step();
    assert_reset();
    step(); step();
    Reset = 1'b1; Value_Valid = 1'b0; step();
    check("rst_no_leak", Seg_Display, 32'h0);

    // Randomized traffic
    repeat (600) begin
      Value_Valid = ($urandom_range(0, 5) == 0);
      Value_In = $urandom;
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 3))
          0: Digit_En = 8'h00;
          1: Digit_En = 8'(1 << $urandom_range(0, 7));
          default: Digit_En = 8'($urandom);
        endcase
      end
      step();
    end

    Value_Valid = 1'b0;
    repeat (2) step();
    @(negedge Clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
